// File: rtl/gouram_trace_serialiser.sv
// Buffers 160-bit Gouram trace records in a small FIFO and streams each one as
// 32-bit words, LSW first. Define GOURAM_SERIAL_HEADER_EN to prefix a header word.
module gouram_trace_serialiser #(
  parameter int RECORD_WIDTH   = 160,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RECORD_WIDTH-1:0]         trace_data_i,
  input  logic                            trace_capture_enable_i,
  input  logic                            lock_i,
  output logic [WORD_WIDTH-1:0]           word_o,
  output logic                            word_valid_o,
  input  logic                            word_ready_i,
  output logic                            word_last_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count_o
);

  localparam int N     = RECORD_WIDTH / WORD_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SEND} state_t;

  logic [RECORD_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [LVL_W-1:0]          r_level;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [WORD_WIDTH-1:0]     r_word;
  logic                      r_valid;
  logic                      r_last;

  logic                      w_accept;
  logic                      w_full;
  logic                      w_hs;
  logic                      w_pop;
  logic                      w_write;
  logic                      w_drop;
  logic [LVL_W-1:0]          w_level_next;
  logic [PTR_W-1:0]          w_rd_ptr_inc;
  logic [IDX_W-1:0]          w_idx_inc;
  logic [RECORD_WIDTH-1:0]   w_head_rec;
  logic [RECORD_WIDTH-1:0]   w_next_rec;
  logic [WORD_WIDTH-1:0]     w_head_words [N];
  logic [WORD_WIDTH-1:0]     w_next_words [N];
  logic [WORD_WIDTH-1:0]     w_head_first;
  logic [WORD_WIDTH-1:0]     w_next_first;

  assign w_accept     = trace_capture_enable_i & lock_i;
  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_hs         = r_valid & word_ready_i;
  assign w_pop        = w_hs & (r_state == S_SEND) & (r_idx == LAST_IDX);
  assign w_write      = w_accept & (~w_full | w_pop);
  assign w_drop       = w_accept & w_full & ~w_pop;
  assign w_level_next = r_level + LVL_W'(w_write) - LVL_W'(w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  assign w_idx_inc    = r_idx + 1'b1;

  // With only the head buffered, a record written on the popping edge is
  // forwarded straight from the input so back-to-back streaming has no bubble.
  assign w_head_rec = r_mem[r_rd_ptr];
  assign w_next_rec = (r_level > LVL_W'(1)) ? r_mem[w_rd_ptr_inc] : trace_data_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign w_head_words[gi] = w_head_rec[gi*WORD_WIDTH +: WORD_WIDTH];
    assign w_next_words[gi] = w_next_rec[gi*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef GOURAM_SERIAL_HEADER_EN
  localparam state_t FIRST_STATE = S_HEADER;
  localparam logic   FIRST_LAST  = 1'b0;

  logic [15:0]           r_seq;
  logic [WORD_WIDTH-1:0] r_hdr_mem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] w_hdr_new;

  assign w_hdr_new    = WORD_WIDTH'({r_seq, 16'(r_drop)});
  assign w_head_first = r_hdr_mem[r_rd_ptr];
  assign w_next_first = (r_level > LVL_W'(1)) ? r_hdr_mem[w_rd_ptr_inc] : w_hdr_new;

  always_ff @(posedge clk) begin
    if (w_write) r_hdr_mem[r_wr_ptr] <= w_hdr_new;
  end

  // Sequence number counts every accepted strobe, including dropped ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_seq <= '0;
    else if (w_accept) r_seq <= r_seq + 1'b1;
  end
`else
  localparam state_t FIRST_STATE = S_SEND;
  localparam logic   FIRST_LAST  = (N == 1);

  assign w_head_first = w_head_words[0];
  assign w_next_first = w_next_words[0];
`endif

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= trace_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_drop   <= '0;
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= w_rd_ptr_inc;
      r_level <= w_level_next;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_level != '0) begin
            r_state <= FIRST_STATE;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_word  <= w_head_first;
            r_last  <= FIRST_LAST;
          end
        end
        S_HEADER: begin
          if (w_hs) begin
            r_state <= S_SEND;
            r_idx   <= '0;
            r_word  <= w_head_words[0];
            r_last  <= (N == 1);
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              if (w_level_next != '0) begin
                r_state <= FIRST_STATE;
                r_idx   <= '0;
                r_word  <= w_next_first;
                r_last  <= FIRST_LAST;
              end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_word  <= '0;
                r_last  <= 1'b0;
              end
            end else begin
              r_idx  <= w_idx_inc;
              r_word <= w_head_words[w_idx_inc];
              r_last <= (w_idx_inc == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = r_valid;
  assign word_last_o  = r_last;
  assign fifo_level_o = r_level;
  assign drop_count_o = r_drop;

endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// Directed and randomised checks of gouram_trace_serialiser against a
// record-queue reference model; honours GOURAM_SERIAL_HEADER_EN.
module tb_gouram_trace_serialiser;

  localparam int RW    = 160;
  localparam int WW    = 32;
  localparam int DEPTH = 4;
  localparam int ND    = RW / WW;
`ifdef GOURAM_SERIAL_HEADER_EN
  localparam int NW = ND + 1;
`else
  localparam int NW = ND;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] trace_data_i = '0;
  logic          trace_capture_enable_i = 1'b0;
  logic          lock_i = 1'b0;
  logic [WW-1:0] word_o;
  logic          word_valid_o;
  logic          word_ready_i = 1'b0;
  logic          word_last_o;
  logic [2:0]    fifo_level_o;
  logic [15:0]   drop_count_o;

  gouram_trace_serialiser #(
    .RECORD_WIDTH(RW), .WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .trace_data_i(trace_data_i),
    .trace_capture_enable_i(trace_capture_enable_i),
    .lock_i(lock_i),
    .word_o(word_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .word_last_o(word_last_o),
    .fifo_level_o(fifo_level_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic [31:0]   hdr;
  } rec_t;

  rec_t        m_q[$];
  bit          m_active;
  int          m_pos;
  logic [15:0] m_drop;
  logic [15:0] m_seq;
  logic [31:0] obs_words[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input rec_t r, input int pos);
`ifdef GOURAM_SERIAL_HEADER_EN
    if (pos == 0) return r.hdr;
    return r.data[(pos-1)*WW +: WW];
`else
    return r.data[pos*WW +: WW];
`endif
  endfunction

  function automatic logic [RW-1:0] rand_rec();
    logic [RW-1:0] r;
    for (int k = 0; k < ND; k++) r[k*WW +: WW] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_pos    = 0;
    m_drop   = '0;
    m_seq    = '0;
  endtask

  // Advance the reference model across one rising edge.
  task automatic model_edge(input logic stb, input logic lk, input logic rdy, input logic [RW-1:0] d);
    int   sz;
    bit   hs, pop, acc, wr, dr;
    rec_t nr;
    sz  = m_q.size();
    hs  = m_active && rdy;
    pop = hs && (m_pos == NW-1);
    acc = stb && lk;
    wr  = acc && ((sz != DEPTH) || pop);
    dr  = acc && (sz == DEPTH) && !pop;
    nr.data = d;
    nr.hdr  = {m_seq, m_drop};
    if (pop) begin
      $display("record out: first data word 0x%08h", m_q[0].data[WW-1:0]);
      void'(m_q.pop_front());
    end
    if (wr) m_q.push_back(nr);
    if (dr && m_drop != 16'hFFFF) m_drop++;
    if (acc) m_seq++;
    if (m_active) begin
      if (pop) begin
        m_active = (m_q.size() != 0);
        m_pos    = 0;
      end else if (hs) m_pos++;
    end else if (sz != 0) begin
      m_active = 1;
      m_pos    = 0;
    end
  endtask

  task automatic check_outputs();
    check("valid", word_valid_o, m_active);
    if (m_active) begin
      check("word", word_o, exp_word(m_q[0], m_pos));
      check("last", word_last_o, m_pos == NW-1);
    end
    check("level", fifo_level_o, m_q.size());
    check("drop", drop_count_o, m_drop);
  endtask

  // One clock: drive inputs, compare at the falling edge, then model the rising edge.
  task automatic step(input logic stb, input logic lk, input logic rdy, input logic [RW-1:0] d);
    trace_capture_enable_i = stb;
    lock_i       = lk;
    word_ready_i = rdy;
    trace_data_i = d;
    @(negedge clk);
    check_outputs();
    if (word_valid_o && rdy) obs_words.push_back(word_o);
    model_edge(stb, lk, rdy, d);
    @(posedge clk);
    #1;
    trace_capture_enable_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", word_valid_o, 1'b0);
    check("rst_level", fifo_level_o, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] single;
    logic [15:0]   drop_before;
    int            hs_count;
    bit            hit;

    model_reset();
    #1;
    check("por_word", word_o, 32'h0);
    check("por_valid", word_valid_o, 1'b0);
    check("por_last", word_last_o, 1'b0);
    check("por_level", fifo_level_o, 3'd0);
    check("por_drop", drop_count_o, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single record, sink always ready
    single = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    obs_words.delete();
    step(1, 1, 1, single);
    check("single_level1", fifo_level_o, 3'd1);
    for (int c = 0; c < NW + 3; c++) step(0, 1, 1, '0);
    check("single_count", obs_words.size(), NW);
    for (int k = 0; k < ND; k++)
      check($sformatf("single_w%0d", k), obs_words[NW-ND+k], 32'h11111111 * (k + 1));
    check("single_level0", fifo_level_o, 3'd0);

    // Backpressure with ready pattern 1,0,0,1
    for (int c = 0; c < 48; c++)
      step((c % 9) == 0, 1, (c % 4 == 0) || (c % 4 == 3), rand_rec());
    for (int c = 0; c < 40; c++) step(0, 1, 1, '0);

    // Overflow: six strobes into a stalled four-deep FIFO
    do_reset();
    for (int c = 0; c < 6; c++) step(1, 1, 0, rand_rec());
    step(0, 1, 0, '0);
    check("ovf_level", fifo_level_o, 3'd4);
    check("ovf_drop", drop_count_o, 16'd2);
    obs_words.delete();
    for (int c = 0; c < 4*NW + 6; c++) step(0, 1, 1, '0);
    check("ovf_words", obs_words.size(), 4*NW);

    // Full FIFO with a strobe on the popping handshake
    do_reset();
    for (int c = 0; c < 4; c++) step(1, 1, 0, rand_rec());
    drop_before = m_drop;
    hit = 0;
    for (int c = 0; c < 3*NW && !hit; c++) begin
      if (m_active && m_pos == NW-1 && m_q.size() == DEPTH) begin
        hit = 1;
        step(1, 1, 1, rand_rec());
      end else step(0, 1, 1, '0);
    end
    check("fullpop_hit", hit, 1'b1);
    check("fullpop_level", fifo_level_o, 3'd4);
    check("fullpop_drop", drop_count_o, drop_before);
    for (int c = 0; c < 5*NW; c++) step(0, 1, 1, '0);

    // Strobes without lock are ignored
    do_reset();
    for (int c = 0; c < 3; c++) step(1, 0, 1, rand_rec());
    step(0, 0, 1, '0);
    check("nolock_drop", drop_count_o, 16'd0);
    check("nolock_valid", word_valid_o, 1'b0);
    check("nolock_level", fifo_level_o, 3'd0);

    // Randomised traffic
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 2) != 0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0), rand_rec());
    for (int c = 0; c < 6*NW; c++) step(0, 1, 1, '0);

    // Reset in the middle of a record
    step(1, 1, 1, rand_rec());
    step(1, 1, 1, rand_rec());
    step(0, 1, 1, '0);
    step(0, 1, 1, '0);
    check("mid_valid_pre", word_valid_o, 1'b1);
    do_reset();
    step(0, 1, 1, '0);
    step(0, 1, 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gouram_trace_serialiser.md
Name: gouram_trace_serialiser

Overview:
- Sits directly downstream of the Gouram trace unit and consumes its 160-bit trace records (`trace_data_o`, `trace_capture_enable`, `lock`).
- Buffers each record in a small FIFO and emits it as a burst of 32-bit words over a valid/ready stream for host/debug readout.
- The tracer cannot be back-pressured, so records arriving while the FIFO is full are dropped and counted.

Parameters:
- RECORD_WIDTH, 160: width of one trace record; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32: width of one output stream word.
- FIFO_DEPTH, 4: number of records buffered; must be a power of 2 and ≥ 2.
- DROP_CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- trace_data_i  input  RECORD_WIDTH  record from the tracer's trace_data_o.
- trace_capture_enable_i  input  1  one-cycle strobe marking trace_data_i valid.
- lock_i  input  1  tracer synchronised; records are accepted only while high.
- word_o  output  WORD_WIDTH  current stream word.
- word_valid_o  output  1  word_o valid.
- word_ready_i  input  1  sink accepts word_o this cycle.
- word_last_o  output  1  high on the final word of a record.
- fifo_level_o  output  clog2(FIFO_DEPTH)+1  records held, including the one being sent.
- drop_count_o  output  DROP_CNT_WIDTH  saturating count of dropped records.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - word_o=0, word_valid_o=0, word_last_o=0.
  - fifo_level_o=0, drop_count_o=0.
  - FSM=IDLE, read and write pointers=0.
- Capture:
  - accept = trace_capture_enable_i & lock_i.
  - If accept and the FIFO is not full, or it is full but a pop occurs in the same cycle, the record is written at the rising edge.
  - If accept, the FIFO is full and there is no pop, the record is discarded and drop_count_o increments, saturating at all-ones.
  - A strobe with lock_i low is ignored and not counted.
- Words per record: N = RECORD_WIDTH/WORD_WIDTH (5 by default). Word k = record bits [k*WORD_WIDTH +: WORD_WIDTH]; least-significant word first.
- FSM:
  - IDLE: word_valid_o=0. If the FIFO is non-empty at an edge, go to SEND with idx=0.
  - SEND: word_valid_o=1, word_o=word idx of the head record, word_last_o=(idx==N-1).
    - On word_valid_o & word_ready_i with idx<N-1: idx increments.
    - On handshake with idx=N-1 (pop): the head record is freed. Go to SEND with idx=0 if another record remains after the pop, else IDLE.
- Latency:
  - A record written at edge E appears as word 0 (valid) after edge E+1 when the FSM was IDLE.
  - Back-to-back records stream with no bubble.
- Handshake rules:
  - word_o and word_last_o are held stable while word_valid_o & !word_ready_i.
  - word_valid_o never drops mid-record except on reset.
- fifo_level_o:
  - Write-only: +1.
  - Pop-only: −1.
  - Write and pop in the same cycle: unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the extra level bit.
- Reset mid-record: the partial record is abandoned and all buffered records are lost; no recovery.

Optional Feature:
- Macro: GOURAM_SERIAL_HEADER_EN.
- When defined:
  - Each record is preceded by one header word: [31:16]=sequence number, [15:0]=low 16 bits of drop_count_o at the record's capture.
  - Sequence number: a 16-bit counter of accepted records, reset to 0, wraps; stored per FIFO entry.
  - FSM gains a HEADER state between IDLE/pop and SEND; a record becomes N+1 words.
  - word_last_o stays on the final data word only.
  - Latency to the first valid word is unchanged (the header is word 0).
- When undefined: no header, no sequence storage, N words per record.

Test Plan:
- Single record: lock_i=1, strobe with data words 0x11111111…0x55555555, word_ready_i=1 → word_o 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555 on 5 consecutive cycles; word_last_o only on 0x55555555; fifo_level_o 1→0.
- Backpressure: word_ready_i toggles 1,0,0,1,… → word_o/word_last_o held through stalls; every word appears exactly once and in order.
- Overflow: word_ready_i=0, 6 strobes with FIFO_DEPTH=4 → fifo_level_o=4, drop_count_o=2; after releasing ready, exactly 4 records (20 words) emerge.
- Full with simultaneous pop: FIFO full, strobe in the same cycle as the last-word handshake → record stored, drop_count_o unchanged, fifo_level_o stays 4.
- lock_i=0: 3 strobes → no writes, drop_count_o=0, word_valid_o=0. Then assert rst mid-record → word_valid_o=0 immediately, fifo_level_o=0.
- With GOURAM_SERIAL_HEADER_EN: two records → header words 0x00000000 then 0x00010000, each followed by its 5 data words.
